// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: control word, operands and indices for EX.
// Optional bubble/flush counter enabled by defining IDEX_PERF_CNT_EN.
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              bubble_i,
  input  logic              flush_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              RegDst_i,
  input  logic [1:0]        ALUOp_i,
  input  logic              ALUSrc_i,
  input  logic [DATA_W-1:0] RS_data_i,
  input  logic [DATA_W-1:0] RT_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [REG_AW-1:0] RS_addr_i,
  input  logic [REG_AW-1:0] RT_addr_i,
  input  logic [REG_AW-1:0] RD_addr_i,
  input  logic [5:0]        funct_i,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic              RegDst_o,
  output logic [1:0]        ALUOp_o,
  output logic              ALUSrc_o,
  output logic [DATA_W-1:0] RS_data_o,
  output logic [DATA_W-1:0] RT_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [REG_AW-1:0] RS_addr_o,
  output logic [REG_AW-1:0] RT_addr_o,
  output logic [REG_AW-1:0] RD_addr_o,
  output logic [5:0]        funct_o,
  output logic              valid_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic [1:0] alu_op;
    logic       alu_src;
  } ctrl_t;

  typedef struct packed {
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic [REG_AW-1:0] rd_addr;
    logic [5:0]        funct;
  } data_t;

  ctrl_t ctrl_in;
  data_t data_in;
  ctrl_t ctrl_q, ctrl_d;
  data_t data_q, data_d;
  logic  valid_q, valid_d;

  assign ctrl_in = '{
    reg_write:  RegWrite_i,
    mem_to_reg: MemtoReg_i,
    mem_read:   MemRead_i,
    mem_write:  MemWrite_i,
    reg_dst:    RegDst_i,
    alu_op:     ALUOp_i,
    alu_src:    ALUSrc_i
  };

  assign data_in = '{
    rs_data: RS_data_i,
    rt_data: RT_data_i,
    imm:     imm_i,
    rs_addr: RS_addr_i,
    rt_addr: RT_addr_i,
    rd_addr: RD_addr_i,
    funct:   funct_i
  };

  // Stall outranks flush, flush outranks bubble.
  always_comb begin
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    valid_d = valid_q;
    priority case (1'b1)
      stall_i: begin
      end
      flush_i: begin
        ctrl_d  = '0;
        data_d  = '0;
        valid_d = 1'b0;
      end
      bubble_i: begin
        ctrl_d  = '0;
        data_d  = data_in;
        valid_d = 1'b0;
      end
      default: begin
        ctrl_d  = ctrl_in;
        data_d  = data_in;
        valid_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

`ifdef IDEX_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of slots killed by flush or bubble.
  always_comb begin
    cnt_d = cnt_q;
    if (!stall_i && (flush_i || bubble_i) && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign bubble_cnt_o = cnt_q;
`else
  assign bubble_cnt_o = '0;
`endif

  assign RegWrite_o = ctrl_q.reg_write;
  assign MemtoReg_o = ctrl_q.mem_to_reg;
  assign MemRead_o  = ctrl_q.mem_read;
  assign MemWrite_o = ctrl_q.mem_write;
  assign RegDst_o   = ctrl_q.reg_dst;
  assign ALUOp_o    = ctrl_q.alu_op;
  assign ALUSrc_o   = ctrl_q.alu_src;
  assign RS_data_o  = data_q.rs_data;
  assign RT_data_o  = data_q.rt_data;
  assign imm_o      = data_q.imm;
  assign RS_addr_o  = data_q.rs_addr;
  assign RT_addr_o  = data_q.rt_addr;
  assign RD_addr_o  = data_q.rd_addr;
  assign funct_o    = data_q.funct;
  assign valid_o    = valid_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: vector table, corner sequences, random vs model.
// Counter checks follow IDEX_PERF_CNT_EN; a CNT_W=2 copy covers saturation.
module tb_id_ex_pipe_reg;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic stall_i = 1'b0;
  logic flush_i = 1'b0;
  logic bubble_i = 1'b0;
  logic [7:0]  in_ctrl;
  logic [31:0] in_rs, in_rt, in_imm;
  logic [4:0]  in_ra, in_rb, in_rd;
  logic [5:0]  in_funct;

  logic rw_o, mtr_o, mr_o, mw_o, rdst_o, asrc_o, valid_o;
  logic [1:0]  aop_o;
  logic [31:0] rs_o, rt_o, imm_o;
  logic [4:0]  ra_o, rb_o, rd_o;
  logic [5:0]  funct_o;
  logic [15:0] cnt_o;

  logic d2_rw, d2_mtr, d2_mr, d2_mw, d2_rdst, d2_asrc, d2_valid;
  logic [1:0]  d2_aop;
  logic [31:0] d2_rs, d2_rt, d2_imm;
  logic [4:0]  d2_ra, d2_rb, d2_rd;
  logic [5:0]  d2_funct;
  logic [1:0]  d2_cnt;

  logic [7:0]   out_ctrl, d2_ctrl;
  logic [116:0] out_data, d2_data, in_data;

  assign out_ctrl = {rw_o, mtr_o, mr_o, mw_o, rdst_o, aop_o, asrc_o};
  assign d2_ctrl  = {d2_rw, d2_mtr, d2_mr, d2_mw, d2_rdst, d2_aop, d2_asrc};
  assign out_data = {rs_o, rt_o, imm_o, ra_o, rb_o, rd_o, funct_o};
  assign d2_data  = {d2_rs, d2_rt, d2_imm, d2_ra, d2_rb, d2_rd, d2_funct};
  assign in_data  = {in_rs, in_rt, in_imm, in_ra, in_rb, in_rd, in_funct};

  id_ex_pipe_reg dut (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i),
    .bubble_i(bubble_i), .flush_i(flush_i),
    .RegWrite_i(in_ctrl[7]), .MemtoReg_i(in_ctrl[6]),
    .MemRead_i(in_ctrl[5]), .MemWrite_i(in_ctrl[4]),
    .RegDst_i(in_ctrl[3]), .ALUOp_i(in_ctrl[2:1]),
    .ALUSrc_i(in_ctrl[0]),
    .RS_data_i(in_rs), .RT_data_i(in_rt), .imm_i(in_imm),
    .RS_addr_i(in_ra), .RT_addr_i(in_rb), .RD_addr_i(in_rd),
    .funct_i(in_funct),
    .RegWrite_o(rw_o), .MemtoReg_o(mtr_o), .MemRead_o(mr_o),
    .MemWrite_o(mw_o), .RegDst_o(rdst_o), .ALUOp_o(aop_o),
    .ALUSrc_o(asrc_o),
    .RS_data_o(rs_o), .RT_data_o(rt_o), .imm_o(imm_o),
    .RS_addr_o(ra_o), .RT_addr_o(rb_o), .RD_addr_o(rd_o),
    .funct_o(funct_o), .valid_o(valid_o), .bubble_cnt_o(cnt_o)
  );

  id_ex_pipe_reg #(.CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i),
    .bubble_i(bubble_i), .flush_i(flush_i),
    .RegWrite_i(in_ctrl[7]), .MemtoReg_i(in_ctrl[6]),
    .MemRead_i(in_ctrl[5]), .MemWrite_i(in_ctrl[4]),
    .RegDst_i(in_ctrl[3]), .ALUOp_i(in_ctrl[2:1]),
    .ALUSrc_i(in_ctrl[0]),
    .RS_data_i(in_rs), .RT_data_i(in_rt), .imm_i(in_imm),
    .RS_addr_i(in_ra), .RT_addr_i(in_rb), .RD_addr_i(in_rd),
    .funct_i(in_funct),
    .RegWrite_o(d2_rw), .MemtoReg_o(d2_mtr), .MemRead_o(d2_mr),
    .MemWrite_o(d2_mw), .RegDst_o(d2_rdst), .ALUOp_o(d2_aop),
    .ALUSrc_o(d2_asrc),
    .RS_data_o(d2_rs), .RT_data_o(d2_rt), .imm_o(d2_imm),
    .RS_addr_o(d2_ra), .RT_addr_o(d2_rb), .RD_addr_o(d2_rd),
    .funct_o(d2_funct), .valid_o(d2_valid), .bubble_cnt_o(d2_cnt)
  );

  always #5 clk = ~clk;

`ifdef IDEX_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Reference slot, expressed as whole bundles.
  logic [7:0]   e_ctrl;
  logic         e_valid;
  logic [116:0] e_data;
  int           e_cnt, e_cnt2;
  int           total = 0;
  int           bad = 0;

  localparam logic [7:0] LW  = 8'b1110_0001;
  localparam logic [7:0] RTY = 8'b1000_1110;
  localparam logic [7:0] SW  = 8'b0001_0001;

  typedef struct {
    logic        stall, flush, bubble;
    logic [7:0]  ctrl;
    logic [31:0] rs, rt;
    logic [5:0]  funct;
    logic [7:0]  x_ctrl;
    logic        x_valid;
    logic [31:0] x_rt;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, req);
    end
  endtask

  task automatic model_reset();
    e_ctrl = '0; e_valid = 1'b0; e_data = '0;
    e_cnt = 0; e_cnt2 = 0;
  endtask

  task automatic model_edge();
    if (!stall_i) begin
      if (flush_i || bubble_i) begin
        e_cnt  = (e_cnt < 65535) ? e_cnt + 1 : 65535;
        e_cnt2 = (e_cnt2 < 3) ? e_cnt2 + 1 : 3;
      end
      if (flush_i) begin
        e_ctrl = '0; e_valid = 1'b0; e_data = '0;
      end else if (bubble_i) begin
        e_ctrl = '0; e_valid = 1'b0; e_data = in_data;
      end else begin
        e_ctrl = in_ctrl; e_valid = 1'b1; e_data = in_data;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ctrl"}, out_ctrl, e_ctrl);
    chk({tag, ".valid"}, valid_o, e_valid);
    chk({tag, ".data"}, out_data, e_data);
    chk({tag, ".cnt"}, cnt_o, PERF ? e_cnt : 0);
    chk({tag, ".cnt2"}, d2_cnt, PERF ? e_cnt2 : 0);
    chk({tag, ".d2slot"}, {d2_ctrl, d2_valid, d2_data},
        {e_ctrl, e_valid, e_data});
    if (!valid_o)
      chk({tag, ".nop"}, {rw_o, mr_o, mw_o}, 3'b000);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input logic [7:0] c, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [5:0] f);
    in_ctrl = c; in_rs = rs; in_rt = rt; in_imm = 32'hFFFF_FFF0;
    in_ra = 5'd3; in_rb = 5'd4; in_rd = 5'd9; in_funct = f;
  endtask

  initial begin
    tbl[0] = '{0, 0, 0, LW,  32'h10, 32'h11, 6'h00, LW,  1, 32'h11};
    tbl[1] = '{0, 0, 0, RTY, 32'h5,  32'h7,  6'h20, RTY, 1, 32'h7};
    tbl[2] = '{0, 0, 1, SW,  32'h1,  32'hA5, 6'h00, 8'h0, 0, 32'hA5};
    tbl[3] = '{0, 0, 0, SW,  32'h1,  32'hA5, 6'h00, SW,  1, 32'hA5};
    tbl[4] = '{0, 1, 1, LW,  32'h2,  32'h33, 6'h00, 8'h0, 0, 32'h0};
    tbl[5] = '{0, 0, 0, LW,  32'h3,  32'h44, 6'h00, LW,  1, 32'h44};

    model_reset();
    set_in(8'hFF, 32'hDEAD_BEEF, 32'hCAFE_F00D, 6'h3F);
    #22;
    check_all("reset_hold");
    @(negedge clk);
    rst_i = 1'b1;

    for (int i = 0; i < 6; i++) begin
      stall_i = tbl[i].stall;
      flush_i = tbl[i].flush;
      bubble_i = tbl[i].bubble;
      set_in(tbl[i].ctrl, tbl[i].rs, tbl[i].rt, tbl[i].funct);
      step();
      chk($sformatf("tbl%0d.ctrl", i), out_ctrl, tbl[i].x_ctrl);
      chk($sformatf("tbl%0d.valid", i), valid_o, tbl[i].x_valid);
      chk($sformatf("tbl%0d.rt", i), rt_o, tbl[i].x_rt);
      check_all($sformatf("tbl%0d", i));
    end
    chk("cnt_after_tbl", cnt_o, PERF ? 16'd2 : 16'd0);

    // Stall with flush pending: freeze, then flush once stall drops.
    stall_i = 0; flush_i = 0; bubble_i = 0;
    set_in(RTY, 32'h5, 32'h7, 6'h20);
    step();
    stall_i = 1; flush_i = 1;
    for (int i = 0; i < 3; i++) begin
      set_in(8'($urandom), $urandom, $urandom, 6'($urandom));
      step();
      chk("stall.ctrl", out_ctrl, RTY);
      chk("stall.rs", rs_o, 32'h5);
      chk("stall.valid", valid_o, 1'b1);
      check_all("stall");
    end
    stall_i = 0;
    step();
    chk("unstall_flush.ctrl", out_ctrl, 8'h0);
    chk("unstall_flush.data", out_data, 117'h0);
    chk("unstall_flush.valid", valid_o, 1'b0);
    flush_i = 0;

    // Async reset mid-cycle, then reset while stalled.
    set_in(LW, 32'h9, 32'h8, 6'h1);
    step();
    rst_i = 1'b0;
    #2;
    model_reset();
    chk("async_rst.valid", valid_o, 1'b0);
    check_all("async_rst");
    @(negedge clk);
    rst_i = 1'b1;
    stall_i = 1;
    step();
    rst_i = 1'b0;
    #1;
    model_reset();
    check_all("rst_in_stall");
    @(negedge clk);
    rst_i = 1'b1;
    stall_i = 0;
    step();
    chk("post_rst.ctrl", out_ctrl, LW);
    check_all("post_rst");

    // Five bubbles saturate the 2-bit counter copy.
    bubble_i = 1;
    for (int i = 0; i < 5; i++) step();
    chk("sat.cnt2", d2_cnt, PERF ? 2'd3 : 2'd0);
    chk("sat.cnt", cnt_o, PERF ? 16'd5 : 16'd0);
    bubble_i = 0;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      stall_i  = ($urandom_range(0, 3) == 0);
      flush_i  = ($urandom_range(0, 9) == 0);
      bubble_i = ($urandom_range(0, 6) == 0);
      in_ctrl = 8'($urandom); in_rs = $urandom; in_rt = $urandom;
      in_imm = $urandom; in_ra = 5'($urandom); in_rb = 5'($urandom);
      in_rd = 5'($urandom); in_funct = 6'($urandom);
      step();
      check_all("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
